// File: rtl/sync_fifo_param_if.sv
//------------------------------------------------------------------------------
// Module   : sync_fifo_param_if
// Purpose  : Handshake/data bundle for the sync_fifo_param elastic buffer.
// Ports    : master = producer/consumer side (drives flush, wr, data_in, rd)
//            slave  = FIFO side (drives data_out, status flags, count)
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface sync_fifo_param_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             flush;
  logic             wr;
  logic [WIDTH-1:0] data_in;
  logic             rd;
  logic [WIDTH-1:0] data_out;
  logic             empty;
  logic             full;
  logic             almost_empty;
  logic             almost_full;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output flush, wr, data_in, rd,
    input  data_out, empty, full, almost_empty, almost_full, count,
           overflow, underflow
  );

  modport slave (
    input  flush, wr, data_in, rd,
    output data_out, empty, full, almost_empty, almost_full, count,
           overflow, underflow
  );
endinterface

`default_nettype wire

// File: rtl/sync_fifo_param.sv
//------------------------------------------------------------------------------
// Module   : sync_fifo_param
// Purpose  : Single-clock parametrised FIFO with occupancy count, programmable
//            almost-full/almost-empty flags, sticky overflow/underflow flags,
//            synchronous flush and registered or fall-through read mode.
// Ports    : clk   - clock, all state changes on the rising edge
//            reset - asynchronous active-high reset
//            bus   - sync_fifo_param_if.slave (flush/wr/data_in/rd in,
//                    data_out/flags/count out)
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module sync_fifo_param #(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 8,
  parameter int AFULL_THRESH  = 6,
  parameter int AEMPTY_THRESH = 2,
  parameter int FWFT          = 0
) (
  input  wire logic        clk,
  input  wire logic        reset,
  sync_fifo_param_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] c_AFULL_THRESH  = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] c_AEMPTY_THRESH = CW'(AEMPTY_THRESH);

  generate
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("sync_fifo_param: DEPTH must be a power of two and >= 2");
    end
    if ((AFULL_THRESH < 1) || (AFULL_THRESH > DEPTH)) begin : g_bad_afull
      $error("sync_fifo_param: AFULL_THRESH must be within 1..DEPTH");
    end
    if (AEMPTY_THRESH >= AFULL_THRESH) begin : g_bad_aempty
      $error("sync_fifo_param: AEMPTY_THRESH must be below AFULL_THRESH");
    end
  endgenerate

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_rd_ptr;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_empty;
  logic             w_full;
  logic [CW-1:0]    w_count;
  logic             w_do_wr;
  logic             w_do_rd;

  // Status is decoded purely from registered pointers, so it never responds
  // combinationally to wr/rd.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                   (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_count = r_wr_ptr - r_rd_ptr;

  // flush swallows same-cycle requests entirely, including their error effects.
  assign w_do_wr = bus.wr && !w_full  && !bus.flush;
  assign w_do_rd = bus.rd && !w_empty && !bus.flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (bus.flush) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_do_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (bus.wr && w_full) begin
        r_overflow <= 1'b1;
      end
      if (bus.rd && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  // Storage carries no reset; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_do_wr) begin
      r_mem[r_wr_ptr[AW-1:0]] <= bus.data_in;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is presented directly; zero while nothing is stored.
      assign bus.data_out = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    end else begin : g_reg_read
      logic [WIDTH-1:0] r_data_out;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_data_out <= '0;
        end else if (bus.flush) begin
          r_data_out <= '0;
        end else if (w_do_rd) begin
          r_data_out <= r_mem[r_rd_ptr[AW-1:0]];
        end
      end

      assign bus.data_out = r_data_out;
    end
  endgenerate

  assign bus.empty        = w_empty;
  assign bus.full         = w_full;
  assign bus.count        = w_count;
  assign bus.almost_empty = (w_count <= c_AEMPTY_THRESH);
  assign bus.almost_full  = (w_count >= c_AFULL_THRESH);
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;
endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
//------------------------------------------------------------------------------
// Module   : tb_sync_fifo_param
// Purpose  : Self-checking bench for sync_fifo_param, one registered-read
//            instance (defaults) and one first-word fall-through instance.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sync_fifo_param;
  logic clk;
  logic reset;

  sync_fifo_param_if #(.WIDTH(8), .DEPTH(8)) f0 ();
  sync_fifo_param_if #(.WIDTH(8), .DEPTH(8)) f1 ();

  sync_fifo_param #(.WIDTH(8), .DEPTH(8), .AFULL_THRESH(6),
                    .AEMPTY_THRESH(2), .FWFT(0)) u_dut_reg (
    .clk(clk), .reset(reset), .bus(f0.slave));

  sync_fifo_param #(.WIDTH(8), .DEPTH(8), .AFULL_THRESH(6),
                    .AEMPTY_THRESH(2), .FWFT(1)) u_dut_fwft (
    .clk(clk), .reset(reset), .bus(f1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       fl;
    logic       wr;
    logic       rd;
    logic [7:0] din;
    logic [7:0] dout;
    logic [3:0] cnt;
    logic [5:0] flags; // {empty, full, almost_empty, almost_full, overflow, underflow}
  } vec_t;

  vec_t vec [19];
  int   n_cmp;
  int   n_err;

  function automatic vec_t mk(input logic fl, input logic wr, input logic rd,
                              input logic [7:0] din, input logic [7:0] dout,
                              input logic [3:0] cnt, input logic [5:0] flags);
    vec_t v;
    v.fl = fl; v.wr = wr; v.rd = rd; v.din = din;
    v.dout = dout; v.cnt = cnt; v.flags = flags;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] flags0();
    return {f0.empty, f0.full, f0.almost_empty, f0.almost_full, f0.overflow, f0.underflow};
  endfunction

  task automatic drive0(input logic fl, input logic wr, input logic rd, input logic [7:0] din);
    f0.flush = fl; f0.wr = wr; f0.rd = rd; f0.data_in = din;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    drive0(1'b0, 1'b0, 1'b0, 8'h00);
    f1.flush = 1'b0; f1.wr = 1'b0; f1.rd = 1'b0; f1.data_in = 8'h00;

    //            fl wr rd din    dout   cnt    E F AE AF OV UD
    vec[0]  = mk(0, 1, 0, 8'h11, 8'h00, 4'd1, 6'b001000);
    vec[1]  = mk(0, 1, 0, 8'h22, 8'h00, 4'd2, 6'b001000);
    vec[2]  = mk(0, 1, 0, 8'h33, 8'h00, 4'd3, 6'b000000);
    vec[3]  = mk(0, 1, 0, 8'h44, 8'h00, 4'd4, 6'b000000);
    vec[4]  = mk(0, 1, 0, 8'h55, 8'h00, 4'd5, 6'b000000);
    vec[5]  = mk(0, 1, 0, 8'h66, 8'h00, 4'd6, 6'b000100);
    vec[6]  = mk(0, 1, 0, 8'h77, 8'h00, 4'd7, 6'b000100);
    vec[7]  = mk(0, 1, 0, 8'h88, 8'h00, 4'd8, 6'b010100);
    vec[8]  = mk(0, 1, 0, 8'h99, 8'h00, 4'd8, 6'b010110);
    vec[9]  = mk(0, 0, 1, 8'h00, 8'h11, 4'd7, 6'b000110);
    vec[10] = mk(0, 0, 1, 8'h00, 8'h22, 4'd6, 6'b000110);
    vec[11] = mk(0, 0, 1, 8'h00, 8'h33, 4'd5, 6'b000010);
    vec[12] = mk(0, 0, 1, 8'h00, 8'h44, 4'd4, 6'b000010);
    vec[13] = mk(0, 0, 1, 8'h00, 8'h55, 4'd3, 6'b000010);
    vec[14] = mk(0, 0, 1, 8'h00, 8'h66, 4'd2, 6'b001010);
    vec[15] = mk(0, 0, 1, 8'h00, 8'h77, 4'd1, 6'b001010);
    vec[16] = mk(0, 0, 1, 8'h00, 8'h88, 4'd0, 6'b101010);
    vec[17] = mk(0, 0, 1, 8'h00, 8'h88, 4'd0, 6'b101011);
    vec[18] = mk(1, 0, 0, 8'h00, 8'h00, 4'd0, 6'b101000);

    // Reset state
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    step();
    check("reset_dout", 32'(f0.data_out), 32'h00);
    check("reset_count", 32'(f0.count), 32'd0);
    check("reset_flags", 32'(flags0()), 32'(6'b101000));
    check("reset_fwft_dout", 32'(f1.data_out), 32'h00);

    // Fill, overflow, drain, underflow, flush
    for (int i = 0; i < 19; i++) begin
      drive0(vec[i].fl, vec[i].wr, vec[i].rd, vec[i].din);
      step();
      check($sformatf("vec%0d_dout", i), 32'(f0.data_out), 32'(vec[i].dout));
      check($sformatf("vec%0d_count", i), 32'(f0.count), 32'(vec[i].cnt));
      check($sformatf("vec%0d_flags", i), 32'(flags0()), 32'(vec[i].flags));
    end

    // Wrap with simultaneous access: preload A0..A2, then 20 wr+rd cycles
    for (int i = 0; i < 3; i++) begin
      drive0(1'b0, 1'b1, 1'b0, 8'(8'hA0 + i));
      step();
    end
    for (int i = 0; i < 20; i++) begin
      drive0(1'b0, 1'b1, 1'b1, 8'(8'hA3 + i));
      step();
      check($sformatf("wrap%0d_dout", i), 32'(f0.data_out), 32'(8'(8'hA0 + i)));
      check($sformatf("wrap%0d_count", i), 32'(f0.count), 32'd3);
      check($sformatf("wrap%0d_err", i), 32'({f0.overflow, f0.underflow}), 32'd0);
    end

    // wr+rd on empty: write accepted, read rejected
    drive0(1'b1, 1'b0, 1'b0, 8'h00);
    step();
    drive0(1'b0, 1'b1, 1'b1, 8'hAB);
    step();
    check("sim_empty_count", 32'(f0.count), 32'd1);
    check("sim_empty_flags", 32'(flags0()), 32'(6'b001001));
    check("sim_empty_dout", 32'(f0.data_out), 32'h00);

    // wr+rd on full: read accepted, write rejected
    drive0(1'b1, 1'b0, 1'b0, 8'h00);
    step();
    for (int i = 0; i < 8; i++) begin
      drive0(1'b0, 1'b1, 1'b0, 8'(8'hC0 + i));
      step();
    end
    check("fill2_flags", 32'(flags0()), 32'(6'b010100));
    drive0(1'b0, 1'b1, 1'b1, 8'hFF);
    step();
    check("sim_full_dout", 32'(f0.data_out), 32'hC0);
    check("sim_full_count", 32'(f0.count), 32'd7);
    check("sim_full_flags", 32'(flags0()), 32'(6'b000110));

    // Flush with wr at count 5, overflow set
    drive0(1'b0, 1'b0, 1'b1, 8'h00);
    step();
    step();
    check("pre_flush_count", 32'(f0.count), 32'd5);
    check("pre_flush_dout", 32'(f0.data_out), 32'hC2);
    drive0(1'b1, 1'b1, 1'b0, 8'h5A);
    step();
    check("flush_count", 32'(f0.count), 32'd0);
    check("flush_flags", 32'(flags0()), 32'(6'b101000));
    check("flush_dout", 32'(f0.data_out), 32'h00);
    drive0(1'b0, 1'b0, 1'b0, 8'h00);
    step();
    check("flush_wr_ignored", 32'(f0.count), 32'd0);

    // FWFT instance: fall-through display and pop
    check("fwft_empty_dout", 32'(f1.data_out), 32'h00);
    f1.wr = 1'b1; f1.data_in = 8'hA5;
    step();
    check("fwft_show_dout", 32'(f1.data_out), 32'hA5);
    check("fwft_show_empty", 32'(f1.empty), 32'd0);
    f1.data_in = 8'hB6;
    step();
    check("fwft_hold_dout", 32'(f1.data_out), 32'hA5);
    check("fwft_hold_count", 32'(f1.count), 32'd2);
    f1.wr = 1'b0; f1.rd = 1'b1;
    step();
    check("fwft_next_dout", 32'(f1.data_out), 32'hB6);
    step();
    f1.rd = 1'b0;
    check("fwft_pop_dout", 32'(f1.data_out), 32'h00);
    check("fwft_pop_empty", 32'(f1.empty), 32'd1);

    // Async reset mid-operation at count 4 with underflow set
    drive0(1'b0, 1'b0, 1'b1, 8'h00);
    step();
    for (int i = 0; i < 5; i++) begin
      drive0(1'b0, 1'b1, 1'b0, 8'(8'h31 + i));
      step();
    end
    drive0(1'b0, 1'b0, 1'b1, 8'h00);
    step();
    drive0(1'b0, 1'b0, 1'b0, 8'h00);
    check("pre_rst_count", 32'(f0.count), 32'd4);
    check("pre_rst_dout", 32'(f0.data_out), 32'h31);
    check("pre_rst_udf", 32'(f0.underflow), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_count", 32'(f0.count), 32'd0);
    check("async_rst_flags", 32'(flags0()), 32'(6'b101000));
    check("async_rst_dout", 32'(f0.data_out), 32'h00);
    #3 reset = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

`default_nettype wire
